// File: rtl/text_screen_pkg.sv
// Shared text-screen constants, cell layout and fetcher state encoding.
// Imported by the screen RAM reader, its cell FIFO and its bus interface.
package text_screen_pkg;

    localparam int unsigned SCREEN_COLUMNS    = 80;
    localparam int unsigned SCREEN_ROWS       = 25;
    localparam int unsigned SCREEN_ADDR_WIDTH = 11;

    localparam int unsigned CODEPOINT_LSB = 0;
    localparam int unsigned ATTRIBUTE_LSB = 8;

    typedef struct packed {
        logic [7:0] codePoint;
        logic [7:0] attribute;
        logic [6:0] column;
        logic       last;
    } cell_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fetch_state_e;

    function automatic cell_t make_cell(logic [15:0] word, logic [6:0] column, logic last);
        cell_t c;
        c.codePoint = word[CODEPOINT_LSB +: 8];
        c.attribute = word[ATTRIBUTE_LSB +: 8];
        c.column    = column;
        c.last      = last;
        return c;
    endfunction

endpackage

// File: rtl/text_cell_fetcher_if.sv
// Screen RAM read port plus the outgoing cell stream of the text cell fetcher.
// master = fetcher side, slave = RAM/pipeline side.
interface text_cell_fetcher_if
    import text_screen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SCREEN_ADDR_WIDTH
) ();

    logic                  ramEnable;
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [15:0]           ramData;
    logic                  cellValid;
    logic                  cellReady;
    logic [7:0]            cellCodePoint;
    logic [7:0]            cellAttribute;
    logic [6:0]            cellColumn;
    logic                  cellLast;

    modport master (
        output ramEnable,
        output ramAddress,
        input  ramData,
        output cellValid,
        input  cellReady,
        output cellCodePoint,
        output cellAttribute,
        output cellColumn,
        output cellLast
    );

    modport slave (
        input  ramEnable,
        input  ramAddress,
        output ramData,
        input  cellValid,
        output cellReady,
        input  cellCodePoint,
        input  cellAttribute,
        input  cellColumn,
        input  cellLast
    );

endinterface

// File: rtl/text_cell_fifo.sv
// Two-entry first-word-fall-through cell FIFO with synchronous flush.
// headCell reads as zero while empty so idle outputs stay at their reset values.
module text_cell_fifo
    import text_screen_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  cell_t      pushCell,
    input  logic       pop,
    output cell_t      headCell,
    output logic [1:0] count
);

    cell_t mem [2];
    logic  wrPtr;
    logic  rdPtr;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushCell;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign headCell = (count == 2'd0) ? '0 : mem[rdPtr];

    // Issue pacing must never let a third cell arrive while two are held.
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            assert (!(push && !pop && count == 2'd2));
        end
    end

endmodule

// File: rtl/text_cell_fetcher.sv
// Walks one character row of screen RAM and streams code point, attribute and
// column to the glyph pipeline, pacing reads so backpressure never drops a cell.
module text_cell_fetcher
    import text_screen_pkg::*;
#(
    parameter int unsigned COLUMNS    = SCREEN_COLUMNS,
    parameter int unsigned ROWS       = SCREEN_ROWS,
    parameter int unsigned ADDR_WIDTH = SCREEN_ADDR_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [4:0]          row,
    input  logic                abort,
    output logic                busy,
    text_cell_fetcher_if.master bus
);

    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] base;
    logic [6:0]            issueCol;
    logic [6:0]            inFlightCol;
    logic                  inFlight;
    logic [1:0]            fifoCount;
    logic [2:0]            committed;
    logic                  pop;
    logic                  issue;
    logic                  drained;
    cell_t                 pushCell;
    cell_t                 headCell;

    assign pop = bus.cellValid & bus.cellReady;

    // Cells already owed to the FIFO; a same-cycle pop frees one slot.
    assign committed = {1'b0, fifoCount} + {2'b00, inFlight};
    assign issue     = (state == StFetch) &&
                       ((committed < 3'd2) || (committed == 3'd2 && pop));
    assign drained   = !inFlight && ((fifoCount == 2'd0) || (fifoCount == 2'd1 && pop));

    assign bus.ramEnable  = issue;
    assign bus.ramAddress = issue ? base + ADDR_WIDTH'(issueCol) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            busy        <= 1'b0;
            base        <= '0;
            issueCol    <= '0;
            inFlightCol <= '0;
            inFlight    <= 1'b0;
        end else if (abort) begin
            state    <= StIdle;
            busy     <= 1'b0;
            issueCol <= '0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= issue;
            if (issue) begin
                inFlightCol <= issueCol;
            end
            unique case (state)
                StIdle: begin
                    if (start && 32'(row) < ROWS) begin
                        base     <= ADDR_WIDTH'(row) * ADDR_WIDTH'(COLUMNS);
                        issueCol <= '0;
                        busy     <= 1'b1;
                        state    <= StFetch;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        issueCol <= issueCol + 7'd1;
                        if (issueCol == 7'(COLUMNS - 1)) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drained) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign pushCell = make_cell(bus.ramData, inFlightCol, inFlightCol == 7'(COLUMNS - 1));

    text_cell_fifo u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (abort),
        .push     (inFlight),
        .pushCell (pushCell),
        .pop      (pop),
        .headCell (headCell),
        .count    (fifoCount)
    );

    assign bus.cellValid     = (fifoCount != 2'd0);
    assign bus.cellCodePoint = headCell.codePoint;
    assign bus.cellAttribute = headCell.attribute;
    assign bus.cellColumn    = headCell.column;
    assign bus.cellLast      = headCell.last;

endmodule

// File: tb/tb_text_cell_fetcher.sv
// Bench for text_cell_fetcher: randomized screen RAM contents and backpressure
// checked against an expected per-row cell list and cycle timeline.
module tb_text_cell_fetcher;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] row;
    logic       abort;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] ram [2048];

    text_cell_fetcher_if bus ();

    text_cell_fetcher dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .row   (row),
        .abort (abort),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous-read screen RAM: data valid the cycle after enable.
    always @(posedge clock) begin
        if (bus.ramEnable) bus.ramData <= ram[bus.ramAddress];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Streams one row and checks it against the expected list of 80 cells.
    // readyMode: 0 = always ready, 1 = toggling, 2 = random.
    task automatic run_row(input int r, input int readyMode, input bit timing,
                           input int busyStartCyc, input bit preStarted, input int chainRow);
        int cyc;
        int nIssued;
        int nxtCol;
        int base;
        bit prevStall;
        logic [15:0] w;
        logic [7:0] pCp;
        logic [7:0] pAt;
        logic [6:0] pCol;
        logic pLast;
        logic [2:0] expSig;
        base = r * 80;
        nIssued = 0;
        nxtCol = 0;
        prevStall = 0;
        pCp = '0; pAt = '0; pCol = '0; pLast = 1'b0;
        if (!preStarted) begin
            @(posedge clock); #1;
            start = 1'b1;
            row = 5'(r);
        end
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 600) begin
            case (readyMode)
                0: bus.cellReady = 1'b1;
                1: bus.cellReady = cyc[0];
                default: bus.cellReady = 1'($urandom_range(0, 1));
            endcase
            if (cyc == busyStartCyc) begin
                start = 1'b1;
                row = 5'((r + 7) % 25);
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (bus.ramEnable) begin
                tests++;
                if (nIssued >= 80 || bus.ramAddress !== 11'(base + nIssued)) begin
                    fails++;
                    $display("FAIL ram_address row %0d issue %0d: got %0d, expected %0d",
                             r, nIssued, bus.ramAddress, base + nIssued);
                end
                nIssued++;
            end
            if (prevStall) begin
                tests++;
                if (bus.cellValid !== 1'b1 || bus.cellCodePoint !== pCp ||
                    bus.cellAttribute !== pAt || bus.cellColumn !== pCol ||
                    bus.cellLast !== pLast) begin
                    fails++;
                    $display("FAIL stall_hold row %0d cyc %0d: got v=%b col=%0d, expected v=1 col=%0d",
                             r, cyc, bus.cellValid, bus.cellColumn, pCol);
                end
            end
            if (bus.cellValid === 1'b1 && bus.cellReady) begin
                tests++;
                w = (nxtCol < 80) ? ram[base + nxtCol] : 16'hxxxx;
                if (nxtCol >= 80 || bus.cellCodePoint !== w[7:0] ||
                    bus.cellAttribute !== w[15:8] || bus.cellColumn !== 7'(nxtCol) ||
                    bus.cellLast !== (nxtCol == 79)) begin
                    fails++;
                    $display("FAIL cell row %0d: got col=%0d cp=%h at=%h last=%b, expected col=%0d cp=%h at=%h last=%b",
                             r, bus.cellColumn, bus.cellCodePoint, bus.cellAttribute,
                             bus.cellLast, nxtCol, w[7:0], w[15:8], nxtCol == 79);
                end
                nxtCol++;
            end
            prevStall = (bus.cellValid === 1'b1) && !bus.cellReady;
            pCp = bus.cellCodePoint;
            pAt = bus.cellAttribute;
            pCol = bus.cellColumn;
            pLast = bus.cellLast;
            if (timing) begin
                expSig = {(cyc >= 1 && cyc <= 80), (cyc >= 3 && cyc <= 82), (cyc <= 82)};
                tests++;
                if ({bus.ramEnable, bus.cellValid, busy} !== expSig) begin
                    fails++;
                    $display("FAIL timing row %0d cyc %0d: got en/valid/busy=%b, expected %b",
                             r, cyc, {bus.ramEnable, bus.cellValid, busy}, expSig);
                end
            end
            if (nxtCol == 80 && busy === 1'b0) break;
            @(posedge clock); #1;
            cyc++;
        end
        tests++;
        if (nxtCol != 80 || nIssued != 80 || busy !== 1'b0) begin
            fails++;
            $display("FAIL row_complete row %0d: got cells=%0d reads=%0d busy=%b, expected 80/80/0",
                     r, nxtCol, nIssued, busy);
        end
        if (chainRow >= 0) begin
            start = 1'b1;
            row = 5'(chainRow);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; row = '0; bus.cellReady = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests++;
        if ({busy, bus.ramEnable, bus.cellValid, bus.cellLast} !== 4'b0 ||
            bus.ramAddress !== 11'd0 || bus.cellCodePoint !== 8'd0 ||
            bus.cellAttribute !== 8'd0 || bus.cellColumn !== 7'd0) begin
            fails++;
            $display("FAIL reset_values: got busy=%b en=%b addr=%0d v=%b, expected all zero",
                     busy, bus.ramEnable, bus.ramAddress, bus.cellValid);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_row0_full_speed;
        run_row(0, 0, 1'b1, -1, 1'b0, -1);
    endtask

    task automatic test_row24_and_invalid;
        run_row(24, 0, 1'b1, -1, 1'b0, -1);
        @(posedge clock); #1;
        start = 1'b1; row = 5'd25;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests++;
            if (busy !== 1'b0 || bus.ramEnable !== 1'b0) begin
                fails++;
                $display("FAIL invalid_row: got busy=%b en=%b, expected 0/0", busy, bus.ramEnable);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_toggle_ready;
        run_row(3, 1, 1'b0, -1, 1'b0, -1);
    endtask

    task automatic test_abort;
        logic [15:0] w;
        @(posedge clock); #1;
        start = 1'b1; row = 5'd1; bus.cellReady = 1'b1;
        for (int cyc = 1; cyc <= 42; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock);
            if (cyc >= 3) begin
                w = ram[80 + cyc - 3];
                tests++;
                if (bus.cellValid !== 1'b1 || bus.cellColumn !== 7'(cyc - 3) ||
                    bus.cellCodePoint !== w[7:0]) begin
                    fails++;
                    $display("FAIL abort_prefix cyc %0d: got v=%b col=%0d, expected v=1 col=%0d",
                             cyc, bus.cellValid, bus.cellColumn, cyc - 3);
                end
            end
        end
        @(posedge clock); #1;
        bus.cellReady = 1'b0; abort = 1'b1;
        @(negedge clock);
        tests++;
        if (bus.cellValid !== 1'b1 || bus.cellColumn !== 7'd40) begin
            fails++;
            $display("FAIL abort_col40: got v=%b col=%0d, expected v=1 col=40",
                     bus.cellValid, bus.cellColumn);
        end
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        tests++;
        if ({bus.cellValid, busy, bus.ramEnable} !== 3'b000) begin
            fails++;
            $display("FAIL abort_flush: got v/busy/en=%b, expected 000",
                     {bus.cellValid, busy, bus.ramEnable});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            tests++;
            if (bus.cellValid !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_stale: got v=%b, expected 0", bus.cellValid);
            end
        end
        run_row(2, 0, 1'b1, -1, 1'b0, -1);
    endtask

    task automatic test_start_while_busy;
        run_row(5, 0, 1'b1, 11, 1'b0, -1);
    endtask

    task automatic test_abort_with_start;
        @(posedge clock); #1;
        start = 1'b1; abort = 1'b1; row = 5'd4;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests++;
            if ({busy, bus.ramEnable, bus.cellValid} !== 3'b000) begin
                fails++;
                $display("FAIL abort_start: got busy/en/v=%b, expected 000",
                         {busy, bus.ramEnable, bus.cellValid});
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid_row;
        @(posedge clock); #1;
        start = 1'b1; row = 5'd6; bus.cellReady = 1'b1;
        for (int cyc = 1; cyc <= 52; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (bus.cellValid !== 1'b1 || bus.cellColumn !== 7'd50) begin
            fails++;
            $display("FAIL reset_mid_pre: got v=%b col=%0d, expected v=1 col=50",
                     bus.cellValid, bus.cellColumn);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        tests++;
        if ({busy, bus.ramEnable, bus.cellValid, bus.cellLast} !== 4'b0 ||
            bus.ramAddress !== 11'd0 || bus.cellCodePoint !== 8'd0 ||
            bus.cellAttribute !== 8'd0 || bus.cellColumn !== 7'd0) begin
            fails++;
            $display("FAIL reset_mid_row: got busy=%b en=%b addr=%0d v=%b col=%0d, expected all zero",
                     busy, bus.ramEnable, bus.ramAddress, bus.cellValid, bus.cellColumn);
        end
        run_row(0, 0, 1'b1, -1, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        run_row(10, 0, 1'b1, -1, 1'b0, 17);
        run_row(17, 0, 1'b1, -1, 1'b1, -1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) begin
            run_row(int'($urandom_range(0, 24)), 2, 1'b0, -1, 1'b0, -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
        bus.ramData = '0;
        test_reset();
        test_row0_full_speed();
        test_row24_and_invalid();
        test_toggle_ready();
        test_abort();
        test_start_while_busy();
        test_abort_with_start();
        test_reset_mid_row();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
